// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared state type, widths and load legality rule for the counter load controller
package counter_ctrl_pkg;

  localparam int ERR_CNT_W = 8;
  localparam int LEGAL_W   = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } ctrl_state_e;

  // Operands arrive zero-extended, so the unsigned compare/modulo of the caller's width is preserved.
  function automatic logic is_legal_load(input logic [LEGAL_W-1:0] value,
                                         input logic [LEGAL_W-1:0] step,
                                         input logic [LEGAL_W-1:0] max);
    if (step == '0) return 1'b0;
    return ((value % step) == '0) && (value < max);
  endfunction

endpackage

// File: rtl/counter_tick_gen.sv
// rtl/counter_tick_gen.sv - prescaler producing one enable tick every PRESCALE running cycles
module counter_tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int                CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count;

  // A restart cycle belongs to the load, so it never produces a tick.
  assign tick = run && !restart && (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart) begin
      count <= '0;
    end else if (run) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/counter_load_ctrl.sv
// rtl/counter_load_ctrl.sv - validates host load requests and drives en/load/data of the step/wrap counter
module counter_load_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int MAX_COUNTER = 7,
  parameter int STEP        = 1,
  parameter int DATA_W      = 32,
  parameter int PRESCALE    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [DATA_W-1:0]    req_data,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic                 cnt_en,
  output logic                 cnt_load,
  output logic [DATA_W-1:0]    cnt_data,
  output logic [DATA_W-1:0]    shadow_cnt,
  output logic                 wrap,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [DATA_W-1:0] MAX_V  = DATA_W'(MAX_COUNTER);
  localparam logic [DATA_W-1:0] STEP_V = DATA_W'(STEP);

  ctrl_state_e       state;
  logic [DATA_W-1:0] req_q;
  logic              req_legal;
  logic              tick;

  assign req_legal = is_legal_load(LEGAL_W'(req_q), LEGAL_W'(STEP_V), LEGAL_W'(MAX_V));

  counter_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .restart (cnt_load),
    .tick    (tick)
  );

  assign cnt_en = tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      req_q     <= '0;
      cnt_load  <= 1'b0;
      cnt_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_q     <= req_data;
            req_ready <= 1'b0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (req_legal) begin
            cnt_load <= 1'b1;
            cnt_data <= req_q;
            state    <= ISSUE;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            if (err_count != '1) err_count <= err_count + 1'b1;
            state     <= RESP;
          end
        end
        ISSUE: begin
          cnt_load  <= 1'b0;
          cnt_data  <= '0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Mirror of the downstream counter: the load wins over an enable, overshoot past MAX wraps to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_cnt <= '0;
      wrap       <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (cnt_load) begin
        shadow_cnt <= cnt_data;
      end else if (cnt_en) begin
        if (shadow_cnt < MAX_V) begin
          shadow_cnt <= shadow_cnt + STEP_V;
        end else begin
          shadow_cnt <= '0;
          wrap       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_load_ctrl.sv
// tb/tb_counter_load_ctrl.sv - randomized scoreboard bench for two configurations of counter_load_ctrl
module tb_counter_load_ctrl;

  localparam int MAX0 = 7;
  localparam int STEP0 = 1;
  localparam int PS0 = 4;
  localparam int MAX1 = 30;
  localparam int STEP1 = 2;
  localparam int PS1 = 1;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n      [2];
  logic        run        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [31:0] req_data   [2];
  logic        rsp_valid  [2];
  logic        rsp_err    [2];
  logic        cnt_en     [2];
  logic        cnt_load   [2];
  logic [31:0] cnt_data   [2];
  logic [31:0] shadow_cnt [2];
  logic        wrap       [2];
  logic [7:0]  err_count  [2];

  int n_checks = 0;
  int n_fail = 0;

  exp_t q0[$];
  exp_t q1[$];

  bit          m_ok    [2];
  int          m_age   [2];
  bit          m_legal [2];
  logic [31:0] m_tx    [2];
  int          m_ph    [2];
  logic [31:0] m_sh    [2];
  bit          m_wrap  [2];
  int          m_err   [2];
  bit          m_acc   [2];

  counter_load_ctrl #(.MAX_COUNTER(MAX0), .STEP(STEP0), .DATA_W(32), .PRESCALE(PS0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .run(run[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_data(req_data[0]), .rsp_valid(rsp_valid[0]), .rsp_err(rsp_err[0]), .cnt_en(cnt_en[0]),
    .cnt_load(cnt_load[0]), .cnt_data(cnt_data[0]), .shadow_cnt(shadow_cnt[0]), .wrap(wrap[0]),
    .err_count(err_count[0]));

  counter_load_ctrl #(.MAX_COUNTER(MAX1), .STEP(STEP1), .DATA_W(32), .PRESCALE(PS1)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .run(run[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_data(req_data[1]), .rsp_valid(rsp_valid[1]), .rsp_err(rsp_err[1]), .cnt_en(cnt_en[1]),
    .cnt_load(cnt_load[1]), .cnt_data(cnt_data[1]), .shadow_cnt(shadow_cnt[1]), .wrap(wrap[1]),
    .err_count(err_count[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input int i, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, i, $time, act, exp);
    end
  endfunction

  function automatic bit legal_ref(input int i, input logic [31:0] d);
    int unsigned mx = (i == 0) ? MAX0 : MAX1;
    int unsigned st = (i == 0) ? STEP0 : STEP1;
    return ((d % st) == 0) && (d < mx);
  endfunction

  function automatic void q_push(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  function automatic int q_size(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t q_front(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void q_drop(input int i);
    if (i == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endfunction

  function automatic void q_clear(input int i);
    if (i == 0) q0.delete();
    else q1.delete();
  endfunction

  // Reference: a transaction is a fixed timeline from its accept edge; counting is run cycles modulo PRESCALE.
  function automatic void mon_step(input int i);
    int unsigned mx = (i == 0) ? MAX0 : MAX1;
    logic [31:0] st = (i == 0) ? STEP0 : STEP1;
    int          ps = (i == 0) ? PS0 : PS1;
    bit e_ready = 1'b0;
    bit e_load  = 1'b0;
    bit e_rsp   = 1'b0;
    bit e_en    = 1'b0;
    exp_t e;
    if (m_ok[i]) begin
      e_ready = (m_age[i] < 0);
      e_load  = m_legal[i] && (m_age[i] == 2);
      e_rsp   = m_legal[i] ? (m_age[i] == 3) : (m_age[i] == 2);
      e_en    = run[i] && (m_ph[i] == ps - 1) && !e_load;
      chk(i, "req_ready", 32'(req_ready[i]), 32'(e_ready));
      chk(i, "cnt_load", 32'(cnt_load[i]), 32'(e_load));
      chk(i, "cnt_data", cnt_data[i], e_load ? m_tx[i] : 32'd0);
      chk(i, "rsp_valid", 32'(rsp_valid[i]), 32'(e_rsp));
      chk(i, "cnt_en", 32'(cnt_en[i]), 32'(e_en));
      chk(i, "shadow_cnt", shadow_cnt[i], m_sh[i]);
      chk(i, "wrap", 32'(wrap[i]), 32'(m_wrap[i]));
      chk(i, "err_count", 32'(err_count[i]), 32'(m_err[i]));
      if (cnt_load[i] === 1'b1) begin
        chk(i, "load_sb_nonempty", 32'(q_size(i) > 0), 32'd1);
        if (q_size(i) > 0) begin
          e = q_front(i);
          chk(i, "load_sb_data", cnt_data[i], e.data);
        end
      end
      if (rsp_valid[i] === 1'b1) begin
        chk(i, "rsp_sb_nonempty", 32'(q_size(i) > 0), 32'd1);
        if (q_size(i) > 0) begin
          e = q_front(i);
          q_drop(i);
          chk(i, "rsp_err", 32'(rsp_err[i]), 32'(e.err));
        end
      end
    end
    m_acc[i] = 1'b0;
    if (!rst_n[i]) begin
      m_ok[i] = 1'b1;
      m_age[i] = -1;
      m_legal[i] = 1'b0;
      m_tx[i] = '0;
      m_ph[i] = 0;
      m_sh[i] = '0;
      m_wrap[i] = 1'b0;
      m_err[i] = 0;
      q_clear(i);
    end else if (m_ok[i]) begin
      m_wrap[i] = e_en && !(m_sh[i] < mx);
      if (e_load) m_sh[i] = m_tx[i];
      else if (e_en) m_sh[i] = (m_sh[i] < mx) ? m_sh[i] + st : 32'd0;
      if (e_load) m_ph[i] = 0;
      else if (run[i]) m_ph[i] = (m_ph[i] + 1) % ps;
      if (!m_legal[i] && m_age[i] == 1 && m_err[i] < 255) m_err[i]++;
      if (m_age[i] >= 0) begin
        m_age[i]++;
        if ((m_legal[i] && m_age[i] == 4) || (!m_legal[i] && m_age[i] == 3)) m_age[i] = -1;
      end else if (req_valid[i]) begin
        m_acc[i] = 1'b1;
        m_age[i] = 1;
        m_tx[i] = req_data[i];
        m_legal[i] = legal_ref(i, req_data[i]);
      end
    end
  endfunction

  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int i, input logic [31:0] d, input bit hold);
    exp_t e;
    bit got = 1'b0;
    e.err = !legal_ref(i, d);
    e.data = d;
    q_push(i, e);
    req_valid[i] = 1'b1;
    req_data[i] = d;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      if (m_acc[i]) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    if (!got) chk(i, "accept_timeout", 32'(got), 32'd1);
    if (!hold || !got) req_valid[i] = 1'b0;
  endtask

  int          ii;
  logic [31:0] dd;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      run[k] = 1'b0;
      req_valid[k] = 1'b0;
      req_data[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    run[0] = 1'b1;
    run[1] = 1'b1;
    idle(40);

    send(0, 32'd3, 1'b0);
    idle(10);
    send(0, 32'd10, 1'b0);
    idle(6);
    send(0, 32'd6, 1'b0);
    send(0, 32'd7, 1'b0);
    send(0, 32'hFFFF_FFFF, 1'b0);
    idle(4);

    send(1, 32'd15, 1'b0);
    send(1, 32'd8, 1'b0);
    idle(20);
    send(1, 32'd32, 1'b0);
    send(1, 32'd28, 1'b0);
    send(1, 32'd30, 1'b0);
    send(1, 32'd0, 1'b0);
    idle(4);

    idle(2);
    run[0] = 1'b0;
    run[1] = 1'b0;
    idle(10);
    run[0] = 1'b1;
    run[1] = 1'b1;
    idle(9);

    send(0, 32'd2, 1'b1);
    send(0, 32'd9, 1'b1);
    send(0, 32'd4, 1'b1);
    send(0, 32'd5, 1'b0);
    send(1, 32'd12, 1'b1);
    send(1, 32'd13, 1'b1);
    send(1, 32'd26, 1'b0);
    idle(6);

    for (int k = 0; k < 80; k++) begin
      ii = int'($urandom_range(0, 1));
      dd = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 40));
      run[$urandom_range(0, 1)] = ($urandom_range(0, 3) != 0);
      send(ii, dd, 1'b0);
      idle(int'($urandom_range(0, 5)));
    end
    run[0] = 1'b1;
    idle(8);

    for (int k = 0; k < 258; k++) send(0, 32'd100, (k < 257));
    idle(4);

    send(0, 32'd3, 1'b0);
    rst_n[0] = 1'b0;
    idle(1);
    rst_n[0] = 1'b1;
    idle(4);
    send(0, 32'd1, 1'b0);
    idle(8);

    chk(0, "sb_drained", 32'(q0.size()), 32'd0);
    chk(1, "sb_drained", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
